soc_system_debounced_pio: RTL and testbench

Parametrised Avalon-MM input PIO for push-buttons and switches. It replaces the fixed 2-bit, falling-edge-only button PIO. Each input bit gets a two-stage synchroniser, a per-bit debounce counter, and a selectable edge detector feeding a sticky edge-capture register. A per-bit interrupt mask drives a level `irq` to the HPS interrupt controller. It sits on the lightweight HPS-to-FPGA bridge in the same place as the existing PIOs.

---
 rtl/soc_system_pio_pkg.sv | 22 ++
 rtl/soc_system_debounced_pio_if.sv | 26 ++
 rtl/soc_system_pio_debounce_bit.sv | 45 ++++
 rtl/soc_system_debounced_pio.sv | 91 +++++++++
 tb/tb_soc_system_debounced_pio.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/soc_system_pio_pkg.sv
// rtl/soc_system_pio_pkg.sv - shared constants and edge helper for the debounced PIO
package soc_system_pio_pkg;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam logic [1:0] PIO_ADDR_DATA         = 2'd0;
    localparam logic [1:0] PIO_ADDR_RAW          = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQ_MASK     = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE_CAPTURE = 2'd3;

    // change marks the cycle the debounced level flips; new_level is the level it flips to
    function automatic logic edge_event(input int mode, input logic change, input logic new_level);
        case (mode)
            EDGE_RISING:  return change & new_level;
            EDGE_FALLING: return change & ~new_level;
            default:      return change;
        endcase
    endfunction

endpackage

// File: rtl/soc_system_debounced_pio_if.sv
// rtl/soc_system_debounced_pio_if.sv - Avalon-MM register bus of the debounced PIO
interface soc_system_debounced_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/soc_system_pio_debounce_bit.sv
// rtl/soc_system_pio_debounce_bit.sv - two-flop synchroniser plus stable-count debounce for one input
module soc_system_pio_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic raw,
    output logic stable,
    output logic change
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    // Asserted in the cycle whose clock edge loads the new level into stable.
    assign change = (sync2 != stable) && (count == LAST);
    assign raw    = sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= IDLE_LEVEL;
            sync2  <= IDLE_LEVEL;
            stable <= IDLE_LEVEL;
            count  <= '0;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
            if (sync2 == stable) begin
                count <= '0;
            end else if (change) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_system_debounced_pio.sv
// rtl/soc_system_debounced_pio.sv - debounced input PIO with edge capture, irq mask and level irq
module soc_system_debounced_pio
    import soc_system_pio_pkg::*;
#(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_MODE       = 1,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic                        clk,
    input  logic                        reset,
    soc_system_debounced_pio_if.slave   bus,
    input  logic [WIDTH-1:0]            in_port,
    output logic                        irq
);

    if (EDGE_MODE < EDGE_RISING || EDGE_MODE > EDGE_ANY) begin : g_bad_edge_mode
        $error("soc_system_debounced_pio: EDGE_MODE must be 0, 1 or 2");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("soc_system_debounced_pio: WIDTH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("soc_system_debounced_pio: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] change;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      read_mux;
    logic             wr;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        soc_system_pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL[g])
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .in_bit (in_port[g]),
            .raw    (raw[g]),
            .stable (stable[g]),
            .change (change[g])
        );

        // raw equals the level stable is about to take whenever change is set
        assign edge_evt[g] = edge_event(EDGE_MODE, change[g], raw[g]);
    end

    assign wr = bus.chipselect && !bus.write_n;

    always_comb begin
        clear_bits = '0;
        if (wr && bus.address == PIO_ADDR_EDGE_CAPTURE) begin
            clear_bits = bus.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        read_mux = '0;
        case (bus.address)
            PIO_ADDR_DATA:         read_mux[WIDTH-1:0] = stable;
            PIO_ADDR_RAW:          read_mux[WIDTH-1:0] = raw;
            PIO_ADDR_IRQ_MASK:     read_mux[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGE_CAPTURE: read_mux[WIDTH-1:0] = edge_capture;
            default:               read_mux            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == PIO_ADDR_IRQ_MASK) begin
                irq_mask <= bus.writedata[WIDTH-1:0];
            end
            // A new event in the same cycle as its clear keeps the bit set.
            edge_capture <= (edge_capture & ~clear_bits) | edge_evt;
            bus.readdata <= read_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_soc_system_debounced_pio.sv
// tb/tb_soc_system_debounced_pio.sv - directed self-checking bench for soc_system_debounced_pio
module tb_soc_system_debounced_pio;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic       irq_a;
    logic       irq_b;
    int         errors = 0;
    int         checks = 0;
    logic [31:0] rd;

    soc_system_debounced_pio_if bus_a ();
    soc_system_debounced_pio_if bus_b ();

    always #5 clk = ~clk;

    soc_system_debounced_pio #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_MODE       (1),
        .IDLE_LEVEL      (2'b11)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_a),
        .in_port (in_a),
        .irq     (irq_a)
    );

    soc_system_debounced_pio #(
        .WIDTH           (2),
        .DEBOUNCE_CYCLES (4),
        .EDGE_MODE       (2),
        .IDLE_LEVEL      (2'b11)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_b),
        .in_port (in_b),
        .irq     (irq_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle(input int sel);
        if (sel == 0) begin
            bus_a.chipselect = 1'b0;
            bus_a.write_n    = 1'b1;
            bus_a.writedata  = '0;
        end else begin
            bus_b.chipselect = 1'b0;
            bus_b.write_n    = 1'b1;
            bus_b.writedata  = '0;
        end
    endtask

    task automatic reg_read(input int sel, input logic [1:0] addr, output logic [31:0] data);
        bus_idle(sel);
        if (sel == 0) bus_a.address = addr;
        else          bus_b.address = addr;
        tick();
        data = (sel == 0) ? bus_a.readdata : bus_b.readdata;
    endtask

    task automatic reg_write(input int sel, input logic [1:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            bus_a.address    = addr;
            bus_a.chipselect = 1'b1;
            bus_a.write_n    = 1'b0;
            bus_a.writedata  = data;
        end else begin
            bus_b.address    = addr;
            bus_b.chipselect = 1'b1;
            bus_b.write_n    = 1'b0;
            bus_b.writedata  = data;
        end
        tick();
        bus_idle(sel);
    endtask

    initial begin
        reset = 1'b1;
        in_a  = 2'b11;
        in_b  = 2'b11;
        bus_a.address = 2'd0;
        bus_b.address = 2'd0;
        bus_idle(0);
        bus_idle(1);

        // 1: reset state and quiet release
        repeat (3) tick();
        check("reset_irq", {31'd0, irq_a}, 32'd0);
        check("reset_readdata", bus_a.readdata, 32'd0);
        reset = 1'b0;
        repeat (8) tick();
        reg_read(0, 2'd0, rd);
        check("idle_data", rd, 32'h3);
        reg_read(0, 2'd3, rd);
        check("idle_edge_capture", rd, 32'h0);
        check("idle_irq", {31'd0, irq_a}, 32'd0);

        // 2: bit0 falling edge, exact latency k+1+DEBOUNCE_CYCLES
        reg_write(0, 2'd2, 32'h1);
        in_a = 2'b10;
        for (int i = 0; i <= 5; i++) begin
            tick();
            check($sformatf("fall_irq_k%0d", i), {31'd0, irq_a}, {31'd0, i == 5});
        end
        repeat (4) tick();
        reg_read(0, 2'd3, rd);
        check("fall_edge_capture", rd, 32'h1);
        reg_read(0, 2'd0, rd);
        check("fall_data", rd, 32'h2);
        reg_read(0, 2'd1, rd);
        check("fall_raw", rd, 32'h2);
        in_a = 2'b11;
        repeat (10) tick();
        reg_read(0, 2'd0, rd);
        check("release_data", rd, 32'h3);
        reg_read(0, 2'd3, rd);
        check("rising_not_captured", rd, 32'h1);

        // 3: 3-cycle glitch on bit1 is rejected
        in_a = 2'b01;
        repeat (3) tick();
        in_a = 2'b11;
        repeat (10) tick();
        reg_read(0, 2'd0, rd);
        check("glitch_data", rd, 32'h3);
        reg_read(0, 2'd3, rd);
        check("glitch_edge_capture", rd, 32'h1);

        // 4: clear coincident with a new bit0 event keeps the bit
        in_a = 2'b10;
        repeat (5) tick();
        reg_write(0, 2'd3, 32'h1);
        check("set_wins_irq", {31'd0, irq_a}, 32'd1);
        reg_read(0, 2'd3, rd);
        check("set_wins_capture", rd, 32'h1);
        reg_write(0, 2'd3, 32'h1);
        check("clear_irq", {31'd0, irq_a}, 32'd0);
        reg_read(0, 2'd3, rd);
        check("clear_capture", rd, 32'h0);
        in_a = 2'b11;
        repeat (10) tick();

        // 5: masked-out bit1 event, then unmask
        in_a = 2'b01;
        repeat (10) tick();
        reg_read(0, 2'd3, rd);
        check("bit1_capture", rd, 32'h2);
        check("bit1_masked_irq", {31'd0, irq_a}, 32'd0);
        reg_write(0, 2'd2, 32'h2);
        check("bit1_unmasked_irq", {31'd0, irq_a}, 32'd1);
        reg_read(0, 2'd2, rd);
        check("mask_read", rd, 32'h2);
        reg_write(0, 2'd0, 32'h0);
        reg_read(0, 2'd0, rd);
        check("data_write_ignored", rd, 32'h1);
        reg_write(0, 2'd3, 32'h3);
        check("clear_all_irq", {31'd0, irq_a}, 32'd0);
        reg_read(0, 2'd3, rd);
        check("clear_all_capture", rd, 32'h0);
        reg_write(0, 2'd2, 32'hFFFF_FFFC);
        reg_read(0, 2'd2, rd);
        check("mask_upper_ignored", rd, 32'h0);
        in_a = 2'b11;
        repeat (10) tick();
        reg_read(0, 2'd1, rd);
        check("final_raw", rd, 32'h3);

        // 6: any-edge instance, press then release of bit0
        reg_read(1, 2'd3, rd);
        check("any_idle_capture", rd, 32'h0);
        in_b = 2'b10;
        repeat (10) tick();
        reg_read(1, 2'd3, rd);
        check("any_press_capture", rd, 32'h1);
        reg_read(1, 2'd0, rd);
        check("any_press_data", rd, 32'h2);
        reg_write(1, 2'd2, 32'h1);
        check("any_press_irq", {31'd0, irq_b}, 32'd1);
        reg_write(1, 2'd3, 32'h1);
        check("any_clear_irq", {31'd0, irq_b}, 32'd0);
        reg_read(1, 2'd3, rd);
        check("any_clear_capture", rd, 32'h0);
        in_b = 2'b11;
        repeat (10) tick();
        reg_read(1, 2'd3, rd);
        check("any_release_capture", rd, 32'h1);
        check("any_release_irq", {31'd0, irq_b}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
